// File: rtl/joybus_bit_encoder.sv
// Joybus transmit serializer: turns handshaked bytes into 4 us MSB-first bit cells
// plus a stop bit, and drives the line driver inputs of the collision detector.
module joybus_bit_encoder #(
  parameter int CLKS_PER_US = 50
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] TX_DATA,
  input  logic       TX_LAST,
  input  logic       TX_VALID,
  output logic       TX_READY,
  input  logic       COLLISION_DETECTED,
  output logic       WRITE_DATA,
  output logic       n_SEND,
  output logic       BUSY,
  output logic       DONE,
  output logic       ABORT,
  output logic       UNDERRUN
);

  localparam int            CW   = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [CW-1:0] QMAX = CW'(CLKS_PER_US - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    STOP
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] qcnt, qcnt_nx;
  logic [1:0]    quarter, quarter_nx;
  logic [2:0]    bit_idx, bit_nx;
  logic [7:0]    data_r, data_nx;
  logic          last_r, last_nx;
  logic          write_nx, nsend_nx, busy_nx;
  logic          done_nx, abort_nx, underrun_nx;

  logic quarter_end, cell_end, byte_end;
  logic accept, collision;

  assign quarter_end = (qcnt == QMAX);
  assign cell_end    = quarter_end && (quarter == 2'd3);
  assign byte_end    = cell_end && (bit_idx == 3'd0);

  // The cycle right after DONE is still closed to new bytes so frames are spaced.
  assign TX_READY = !RESET &&
                    (((state == IDLE) && !DONE) ||
                     ((state == SEND) && !last_r && byte_end));

  assign accept    = TX_VALID && TX_READY;
  assign collision = COLLISION_DETECTED && !n_SEND;

  always_comb begin
    // NOTE: every next-state variable gets a default first so no latch is inferred.
    state_nx    = state;
    qcnt_nx     = qcnt;
    quarter_nx  = quarter;
    bit_nx      = bit_idx;
    data_nx     = data_r;
    last_nx     = last_r;
    write_nx    = WRITE_DATA;
    nsend_nx    = n_SEND;
    busy_nx     = BUSY;
    done_nx     = 1'b0;
    abort_nx    = 1'b0;
    underrun_nx = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx   = SEND;
          qcnt_nx    = '0;
          quarter_nx = 2'd0;
          bit_nx     = 3'd7;
          data_nx    = TX_DATA;
          last_nx    = TX_LAST;
          busy_nx    = 1'b1;
          nsend_nx   = 1'b0;
          write_nx   = 1'b0;
        end
      end

      SEND: begin
        if (!quarter_end) begin
          qcnt_nx = qcnt + CW'(1);
        end else begin
          qcnt_nx    = '0;
          quarter_nx = quarter + 2'd1;
          if (cell_end) begin
            if (bit_idx != 3'd0) begin
              bit_nx = bit_idx - 3'd1;
            end else if (accept) begin
              bit_nx  = 3'd7;
              data_nx = TX_DATA;
              last_nx = TX_LAST;
            end else begin
              state_nx    = STOP;
              underrun_nx = !last_r;
            end
          end
        end

        if (state_nx == SEND) begin
          // Cell shape: low, data, data, high.
          unique case (quarter_nx)
            2'd0:    write_nx = 1'b0;
            2'd3:    write_nx = 1'b1;
            default: write_nx = data_nx[bit_nx];
          endcase
        end else begin
          write_nx = 1'b0;
        end
      end

      STOP: begin
        if (quarter_end) begin
          state_nx = IDLE;
          qcnt_nx  = '0;
          nsend_nx = 1'b1;
          write_nx = 1'b1;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end else begin
          qcnt_nx = qcnt + CW'(1);
        end
      end

      default: state_nx = IDLE;
    endcase

    // A collision while driving beats everything, including a byte accepted this cycle.
    if (collision) begin
      state_nx    = IDLE;
      qcnt_nx     = '0;
      quarter_nx  = 2'd0;
      bit_nx      = 3'd7;
      nsend_nx    = 1'b1;
      write_nx    = 1'b1;
      busy_nx     = 1'b0;
      done_nx     = 1'b0;
      underrun_nx = 1'b0;
      abort_nx    = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      state      <= IDLE;
      qcnt       <= '0;
      quarter    <= 2'd0;
      bit_idx    <= 3'd7;
      data_r     <= '0;
      last_r     <= 1'b0;
      WRITE_DATA <= 1'b1;
      n_SEND     <= 1'b1;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ABORT      <= 1'b0;
      UNDERRUN   <= 1'b0;
    end else begin
      state      <= state_nx;
      qcnt       <= qcnt_nx;
      quarter    <= quarter_nx;
      bit_idx    <= bit_nx;
      data_r     <= data_nx;
      last_r     <= last_nx;
      WRITE_DATA <= write_nx;
      n_SEND     <= nsend_nx;
      BUSY       <= busy_nx;
      DONE       <= done_nx;
      ABORT      <= abort_nx;
      UNDERRUN   <= underrun_nx;
    end
  end

endmodule

// File: tb/tb_joybus_bit_encoder.sv
// Directed bench for joybus_bit_encoder with CLKS_PER_US=4 (16-cycle bit cells,
// 128-cycle bytes); cycle t is the handshake cycle, logs index cycles t+1 onward.
module tb_joybus_bit_encoder;

  logic       clk_tb = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       collision = 1'b0;
  logic       write_data, n_send, busy, done, abort_pulse, underrun;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic wd_log   [0:299];
  logic ns_log   [0:299];
  logic busy_log [0:299];
  logic done_log [0:299];
  logic abrt_log [0:299];
  logic und_log  [0:299];
  logic rdy_log  [0:299];

  always #5 clk_tb = ~clk_tb;

  joybus_bit_encoder #(.CLKS_PER_US(4)) dut (
    .CLK                (clk_tb),
    .RESET              (rst),
    .TX_DATA            (tx_data),
    .TX_LAST            (tx_last),
    .TX_VALID           (tx_valid),
    .TX_READY           (tx_ready),
    .COLLISION_DETECTED (collision),
    .WRITE_DATA         (write_data),
    .n_SEND             (n_send),
    .BUSY               (busy),
    .DONE               (done),
    .ABORT              (abort_pulse),
    .UNDERRUN           (underrun)
  );

  task automatic tick();
    @(posedge clk_tb);
    #1;
  endtask

  // Expected line level k cycles (1..128) into a byte: 4 quarters of 4 cycles per bit.
  function automatic logic exp_level(input logic [7:0] b, input int k);
    int c;
    int q;
    c = (k - 1) / 16;
    q = ((k - 1) % 16) / 4;
    if (q == 0) return 1'b0;
    if (q == 3) return 1'b1;
    return b[7 - c];
  endfunction

  function automatic int frame_bad(input logic [7:0] b, input int off);
    int bad;
    bad = 0;
    for (int k = 1; k <= 128; k++)
      if (wd_log[off + k] !== exp_level(b, k)) bad++;
    return bad;
  endfunction

  function automatic int count_ones(input int which, input int lo, input int hi);
    int n;
    n = 0;
    for (int i = lo; i <= hi; i++) begin
      case (which)
        0: if (done_log[i] === 1'b1) n++;
        1: if (abrt_log[i] === 1'b1) n++;
        2: if (und_log[i]  === 1'b1) n++;
        3: if (rdy_log[i]  === 1'b1) n++;
        4: if (ns_log[i]   === 1'b1) n++;
        default: if (busy_log[i] === 1'b1) n++;
      endcase
    end
    return n;
  endfunction

  // Log n cycles; optionally pulse collision or reset in one of them. Drops VALID after a handshake.
  task automatic capture(input int n, input int coll_at, input int rst_at);
    logic took;
    for (int i = 1; i <= n; i++) begin
      rst       = (i == rst_at);
      collision = (i == coll_at);
      #1;
      wd_log[i]   = write_data;
      ns_log[i]   = n_send;
      busy_log[i] = busy;
      done_log[i] = done;
      abrt_log[i] = abort_pulse;
      und_log[i]  = underrun;
      rdy_log[i]  = tx_ready;
      took = tx_valid && tx_ready;
      tick();
      if (took) tx_valid = 1'b0;
    end
    rst       = 1'b0;
    collision = 1'b0;
  endtask

  // Hand over a byte in the current cycle t; returns in cycle t+1 with garbage on the data bus.
  task automatic offer_first(input logic [7:0] b, input logic last);
    tx_data  = b;
    tx_last  = last;
    tx_valid = 1'b1;
    #1;
    chk_cnt++;
    if (tx_ready !== 1'b1) $display("FAIL idle_ready: got %b expected 1", tx_ready);
    else pass_cnt++;
    tick();
    tx_valid = 1'b0;
    tx_data  = ~b;
    tx_last  = ~last;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_valid = 1'b0;
    collision = 1'b0;
    repeat (3) tick();
    chk_cnt++;
    if (tx_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", tx_ready);
    else pass_cnt++;
    chk_cnt++;
    if ({write_data, n_send, busy} !== 3'b110)
      $display("FAIL reset_line: got wd/ns/busy=%b expected 110", {write_data, n_send, busy});
    else pass_cnt++;
    chk_cnt++;
    if ({done, abort_pulse, underrun} !== 3'b000)
      $display("FAIL reset_pulses: got %b expected 000", {done, abort_pulse, underrun});
    else pass_cnt++;
    rst = 1'b0;
    #1;
    chk_cnt++;
    if (tx_ready !== 1'b1) $display("FAIL release_ready: got %b expected 1", tx_ready);
    else pass_cnt++;
  endtask

  task automatic test_single_byte();
    offer_first(8'h40, 1'b1);
    capture(134, 0, 0);
    chk_cnt++;
    if ({wd_log[1], wd_log[12], wd_log[13], wd_log[16]} !== 4'b0011)
      $display("FAIL bit7_cell: got %b expected 0011", {wd_log[1], wd_log[12], wd_log[13], wd_log[16]});
    else pass_cnt++;
    chk_cnt++;
    if ({wd_log[17], wd_log[20], wd_log[21], wd_log[32]} !== 4'b0011)
      $display("FAIL bit6_cell: got %b expected 0011", {wd_log[17], wd_log[20], wd_log[21], wd_log[32]});
    else pass_cnt++;
    chk_cnt++;
    if (frame_bad(8'h40, 0) !== 0)
      $display("FAIL wave_40: got %0d bad cycles expected 0", frame_bad(8'h40, 0));
    else pass_cnt++;
    chk_cnt++;
    if ({wd_log[129], wd_log[132], ns_log[129], ns_log[132]} !== 4'b0000)
      $display("FAIL stop_40: got %b expected 0000", {wd_log[129], wd_log[132], ns_log[129], ns_log[132]});
    else pass_cnt++;
    chk_cnt++;
    if ({ns_log[133], wd_log[133], done_log[133], busy_log[133]} !== 4'b1110)
      $display("FAIL done_40: got ns/wd/done/busy=%b expected 1110",
               {ns_log[133], wd_log[133], done_log[133], busy_log[133]});
    else pass_cnt++;
    chk_cnt++;
    if (count_ones(0, 1, 134) !== 1) $display("FAIL done_count_40: got %0d expected 1", count_ones(0, 1, 134));
    else pass_cnt++;
    chk_cnt++;
    if (count_ones(5, 1, 132) !== 132) $display("FAIL busy_40: got %0d expected 132", count_ones(5, 1, 132));
    else pass_cnt++;
    chk_cnt++;
    if ({count_ones(3, 1, 133), rdy_log[134]} !== {32'sd0, 1'b1})
      $display("FAIL ready_40: got %0d in frame, %b after, expected 0 and 1", count_ones(3, 1, 133), rdy_log[134]);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    offer_first(8'h00, 1'b0);
    tx_data  = 8'hFF;
    tx_last  = 1'b1;
    tx_valid = 1'b1;
    capture(262, 0, 0);
    chk_cnt++;
    if ({count_ones(3, 1, 260), rdy_log[128]} !== {32'sd1, 1'b1})
      $display("FAIL b2b_ready: got %0d high, rdy[128]=%b expected 1 and 1", count_ones(3, 1, 260), rdy_log[128]);
    else pass_cnt++;
    chk_cnt++;
    if (count_ones(4, 1, 260) !== 0) $display("FAIL b2b_nsend: got %0d released cycles expected 0", count_ones(4, 1, 260));
    else pass_cnt++;
    chk_cnt++;
    if (frame_bad(8'h00, 0) + frame_bad(8'hFF, 128) !== 0)
      $display("FAIL b2b_wave: got %0d bad cycles expected 0", frame_bad(8'h00, 0) + frame_bad(8'hFF, 128));
    else pass_cnt++;
    chk_cnt++;
    if ({wd_log[257], wd_log[260], done_log[260], done_log[261], ns_log[261]} !== 5'b00011)
      $display("FAIL b2b_end: got %b expected 00011",
               {wd_log[257], wd_log[260], done_log[260], done_log[261], ns_log[261]});
    else pass_cnt++;
    chk_cnt++;
    if (count_ones(2, 1, 262) !== 0) $display("FAIL b2b_underrun: got %0d expected 0", count_ones(2, 1, 262));
    else pass_cnt++;
  endtask

  task automatic test_underrun();
    offer_first(8'hA5, 1'b0);
    capture(134, 0, 0);
    chk_cnt++;
    if (frame_bad(8'hA5, 0) !== 0) $display("FAIL wave_a5: got %0d bad cycles expected 0", frame_bad(8'hA5, 0));
    else pass_cnt++;
    chk_cnt++;
    if ({rdy_log[127], rdy_log[128]} !== 2'b01)
      $display("FAIL ur_ready: got %b expected 01", {rdy_log[127], rdy_log[128]});
    else pass_cnt++;
    chk_cnt++;
    if ({und_log[129], count_ones(2, 1, 134)} !== {1'b1, 32'sd1})
      $display("FAIL ur_pulse: got und[129]=%b count=%0d expected 1 and 1", und_log[129], count_ones(2, 1, 134));
    else pass_cnt++;
    chk_cnt++;
    if ({wd_log[129], wd_log[132], ns_log[132], done_log[132], done_log[133], ns_log[133]} !== 6'b000011)
      $display("FAIL ur_stop: got %b expected 000011",
               {wd_log[129], wd_log[132], ns_log[132], done_log[132], done_log[133], ns_log[133]});
    else pass_cnt++;
  endtask

  task automatic test_collision();
    // Ignored while the line is released.
    collision = 1'b1;
    #1;
    tick();
    collision = 1'b0;
    chk_cnt++;
    if ({abort_pulse, n_send, tx_ready} !== 3'b011)
      $display("FAIL idle_collision: got abort/ns/rdy=%b expected 011", {abort_pulse, n_send, tx_ready});
    else pass_cnt++;

    offer_first(8'hFF, 1'b1);
    capture(40, 20, 0);
    chk_cnt++;
    if ({ns_log[20], abrt_log[20]} !== 2'b00)
      $display("FAIL coll_before: got %b expected 00", {ns_log[20], abrt_log[20]});
    else pass_cnt++;
    chk_cnt++;
    if ({abrt_log[21], ns_log[21], wd_log[21], busy_log[21], rdy_log[21]} !== 5'b11101)
      $display("FAIL coll_abort: got abort/ns/wd/busy/rdy=%b expected 11101",
               {abrt_log[21], ns_log[21], wd_log[21], busy_log[21], rdy_log[21]});
    else pass_cnt++;
    chk_cnt++;
    if ({count_ones(0, 1, 40), count_ones(1, 1, 40)} !== {32'sd0, 32'sd1})
      $display("FAIL coll_pulses: got done=%0d abort=%0d expected 0 and 1", count_ones(0, 1, 40), count_ones(1, 1, 40));
    else pass_cnt++;

    // Collision in the same cycle as a mid-frame accept: the new byte is dropped.
    offer_first(8'h00, 1'b0);
    tx_data  = 8'h55;
    tx_last  = 1'b1;
    tx_valid = 1'b1;
    capture(140, 128, 0);
    chk_cnt++;
    if ({rdy_log[128], abrt_log[129], ns_log[129], busy_log[129]} !== 4'b1110)
      $display("FAIL coll_accept: got rdy/abort/ns/busy=%b expected 1110",
               {rdy_log[128], abrt_log[129], ns_log[129], busy_log[129]});
    else pass_cnt++;
    chk_cnt++;
    if ({count_ones(4, 129, 140), count_ones(0, 1, 140)} !== {32'sd12, 32'sd0})
      $display("FAIL coll_discard: got released=%0d done=%0d expected 12 and 0",
               count_ones(4, 129, 140), count_ones(0, 1, 140));
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    offer_first(8'hFF, 1'b1);
    capture(60, 0, 50);
    chk_cnt++;
    if ({ns_log[50], rdy_log[50]} !== 2'b00)
      $display("FAIL mid_rst_before: got ns/rdy=%b expected 00", {ns_log[50], rdy_log[50]});
    else pass_cnt++;
    chk_cnt++;
    if ({ns_log[51], busy_log[51], wd_log[51], rdy_log[51]} !== 4'b1011)
      $display("FAIL mid_rst_after: got ns/busy/wd/rdy=%b expected 1011",
               {ns_log[51], busy_log[51], wd_log[51], rdy_log[51]});
    else pass_cnt++;
    chk_cnt++;
    if (count_ones(0, 1, 60) + count_ones(1, 1, 60) !== 0)
      $display("FAIL mid_rst_pulses: got %0d expected 0", count_ones(0, 1, 60) + count_ones(1, 1, 60));
    else pass_cnt++;

    offer_first(8'hC3, 1'b1);
    capture(134, 0, 0);
    chk_cnt++;
    if (frame_bad(8'hC3, 0) !== 0) $display("FAIL wave_c3: got %0d bad cycles expected 0", frame_bad(8'hC3, 0));
    else pass_cnt++;
    chk_cnt++;
    if ({wd_log[130], done_log[132], done_log[133]} !== 3'b001)
      $display("FAIL done_c3: got %b expected 001", {wd_log[130], done_log[132], done_log[133]});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_underrun();
    test_collision();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/joybus_bit_encoder.md
Name: joybus_bit_encoder

Overview:
- Transmit-side serializer for the GameCube joybus data line.
- Accepts bytes over a valid/ready handshake and shifts them out MSB-first as 4 µs joybus bit cells, followed by a stop bit.
- Drives WRITE_DATA and n_SEND, the inputs of collision_detector.
- Consumes that block's COLLISION_DETECTED to abort a transfer.

Parameters:
- CLKS_PER_US, 50: CLK cycles per 1 µs quarter-cell; legal range 2..1023.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- TX_DATA  input  8  byte to send, MSB transmitted first.
- TX_LAST  input  1  qualifies TX_DATA as the final byte of the frame.
- TX_VALID  input  1  TX_DATA/TX_LAST valid.
- TX_READY  output  1  byte accepted on a cycle where TX_VALID=1 and TX_READY=1.
- COLLISION_DETECTED  input  1  from collision_detector.
- WRITE_DATA  output  1  line level to drive; 0 = pull low.
- n_SEND  output  1  active-low driver enable; 1 = line released.
- BUSY  output  1  high from byte acceptance until return to IDLE.
- DONE  output  1  one-cycle pulse after the stop bit completes normally.
- ABORT  output  1  one-cycle pulse when a collision ends the frame.
- UNDERRUN  output  1  one-cycle pulse when a non-last byte ends with no next byte.

Behaviour:
- All outputs registered except TX_READY.
- Reset values: WRITE_DATA=1, n_SEND=1, BUSY=0, DONE=0, ABORT=0, UNDERRUN=0, state=IDLE.
- TX_READY is forced to 0 while RESET=1.

Timing:
- Quarter counter runs 0..CLKS_PER_US-1. Quarter index q runs 0..3. Bit index runs 7..0.
- Bit cell for value b: q0 = 0; q1 = b; q2 = b; q3 = 1.
  - Bit 0 → 3 µs low, 1 µs high.
  - Bit 1 → 1 µs low, 3 µs high.
- One byte = 32*CLKS_PER_US cycles.

States:
- IDLE: TX_READY=1.
  - On accept at cycle t: latch the byte and TX_LAST, set BUSY=1.
  - From t+1: n_SEND=0, WRITE_DATA=0, enter SEND.
- SEND: shifts out bit cells.
  - TX_READY=1 only in the final CLK of bit index 0, and only when the latched last flag = 0.
  - If accepted there, the new byte's first cell starts on the next cycle with no gap.
  - If the latched last flag = 1 → STOP.
  - If last flag = 0 but no accept occurred → STOP, with a UNDERRUN pulse coincident with STOP entry.
- STOP: WRITE_DATA=0 for CLKS_PER_US cycles.
  - Next cycle: n_SEND=1, WRITE_DATA=1, BUSY=0, DONE=1 for one cycle, enter IDLE.
  - TX_READY becomes 1 on the following cycle.

Collision:
- COLLISION_DETECTED is acted on only while n_SEND=0.
- A high sample in cycle c gives, at c+1: n_SEND=1, WRITE_DATA=1, ABORT=1 pulse, BUSY=0, state=IDLE.
- The latched byte is discarded. No stop bit, no DONE.
- COLLISION_DETECTED is ignored in IDLE.

Simultaneous events:
- Collision on the same cycle as a mid-frame accept: abort wins; the accepted byte is discarded.
- RESET during any state: outputs return to reset values on the next edge; no DONE/ABORT pulse.
- TX_DATA and TX_LAST are don't-care when not accepted. Changes while BUSY have no effect on the cell being sent.

Test Plan:
1. CLKS_PER_US=4; reset 3 cycles → WRITE_DATA=1, n_SEND=1, BUSY=0, TX_READY=0 during reset and 1 on the cycle after release.
2. Accept 0x40 with TX_LAST=1 at cycle t.
   - Bit7 (0): WRITE_DATA low for t+1..t+12, high for t+13..t+16.
   - Bit6 (1): low for t+17..t+20, high for t+21..t+32.
   - Stop low for t+129..t+132.
   - n_SEND=1 and DONE=1 at t+133.
3. 0x00 (TX_LAST=0) then 0xFF (TX_LAST=1) offered back-to-back.
   - TX_READY is high only at t+128 during the frame.
   - n_SEND stays 0 continuously for t+1..t+260.
   - DONE=1 at t+261.
4. 0xA5 with TX_LAST=0 and no second byte → UNDERRUN pulse at t+129, stop bit t+129..t+132, DONE at t+133.
5. Assert COLLISION_DETECTED at t+20 during 0xFF → ABORT=1, n_SEND=1, WRITE_DATA=1 at t+21; no DONE; TX_READY=1 at t+21.
6. RESET asserted at t+50 mid-byte → n_SEND=1, BUSY=0 at t+51; no DONE/ABORT pulse; next frame transmits normally.
